// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: clear-FSM encoding and
// the legal port-count ranges.
package regfile_mp_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam int NRD_MIN = 1;
  localparam int NRD_MAX = 4;
  localparam int NWR_MIN = 1;
  localparam int NWR_MAX = 2;

endpackage

// File: rtl/regfile_mp_sb.sv
// Pending-bit scoreboard: one bit per register, set by alloc, cleared by a
// committing write, bulk-flushed on clear entry, looked up per read port.
module regfile_sb
  import regfile_mp_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              set_en_i,
  input  logic [AW-1:0]     set_addr_i,
  input  logic [NWR-1:0]    clr_en_i,
  input  logic [NWR*AW-1:0] clr_addr_i,
  input  logic [NRD*AW-1:0] look_addr_i,
  output logic [NRD-1:0]    look_pend_o
);

  if (NRD < NRD_MIN || NRD > NRD_MAX) begin : g_bad_nrd
    $error("regfile_sb: NRD out of range");
  end
  if (NWR < NWR_MIN || NWR > NWR_MAX) begin : g_bad_nwr
    $error("regfile_sb: NWR out of range");
  end

  logic [NREGS-1:0] pend_q, pend_d;

  // Set is applied after the clears so alloc wins over a same-cycle write.
  always_comb begin
    pend_d = pend_q;
    for (int j = 0; j < NWR; j++) begin
      if (clr_en_i[j]) pend_d[clr_addr_i[j*AW +: AW]] = 1'b0;
    end
    if (set_en_i) pend_d[set_addr_i] = 1'b1;
    pend_d[0] = 1'b0;
    if (flush_i) pend_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  always_comb begin
    look_pend_o = '0;
    for (int i = 0; i < NRD; i++) begin
      look_pend_o[i] = pend_q[look_addr_i[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, pending scoreboard and a
// one-register-per-cycle bulk clear sequence (also run out of reset).
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_req,
  output logic                busy,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rd_pend,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr
);

  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            enter_clear;
  logic            alloc_ok;
  logic [NWR-1:0]  wcommit;
  logic [AW-1:0]   waddr [NWR];
  logic [XLEN-1:0] wdat  [NWR];
  logic [NRD-1:0]  sb_pend;
  logic [XLEN-1:0] mem_q [NREGS];

  assign busy     = (state_q == ST_CLEAR);
  assign alloc_ok = alloc_en && (alloc_addr != '0) && !busy;

  for (genvar j = 0; j < NWR; j++) begin : g_wr
    assign waddr[j]   = wa[j*AW +: AW];
    assign wdat[j]    = wd[j*XLEN +: XLEN];
    assign wcommit[j] = we[j] && (waddr[j] != '0) && !busy;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    enter_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d     = ST_CLEAR;
          cnt_d       = '0;
          enter_clear = 1'b1;
        end
      end
      default: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(NREGS - 1)) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage has no reset; the clear sequence zeroes it. Higher port index wins.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wcommit[j]) mem_q[waddr[j]] <= wdat[j];
      end
    end
  end

  regfile_sb #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .AW    (AW)
  ) u_sb (
    .clk_i       (clk),
    .rst_ni      (rst),
    .flush_i     (enter_clear),
    .set_en_i    (alloc_ok),
    .set_addr_i  (alloc_addr),
    .clr_en_i    (wcommit),
    .clr_addr_i  (wa),
    .look_addr_i (ra),
    .look_pend_o (sb_pend)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            pnd;

    assign addr = ra[i*AW +: AW];

    always_comb begin
      data = mem_q[addr];
      pnd  = sb_pend[i];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wcommit[j] && (waddr[j] == addr)) begin
            data = wdat[j];
            pnd  = 1'b0;
          end
        end
      end
      if (busy || (addr == '0)) begin
        data = '0;
        pnd  = 1'b0;
      end
    end

    assign rd[i*XLEN +: XLEN] = data;
    assign rd_pend[i]         = pnd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (32x32, 2R/2W, bypass on): vector table for
// single-cycle behaviour plus sequences for clear and reset.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic        clr_req;
  logic        busy;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rd_pend;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic        alloc_en;
  logic [4:0]  alloc_addr;

  int checks = 0;
  int errors = 0;

  regfile_mp #(
    .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
    .ra(ra), .rd(rd), .rd_pend(rd_pend),
    .we(we), .wa(wa), .wd(wd),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        al_en;
    logic [4:0]  al_a;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  ep;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(logic [1:0] w, logic [4:0] a0, logic [31:0] d0,
                              logic [4:0] a1, logic [31:0] d1, logic ae,
                              logic [4:0] aa, logic [4:0] r0, logic [4:0] r1,
                              logic [31:0] x0, logic [31:0] x1, logic [1:0] xp);
    vec_t v;
    v.we = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1;
    v.al_en = ae; v.al_a = aa; v.ra0 = r0; v.ra1 = r1;
    v.e0 = x0; v.e1 = x1; v.ep = xp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    clr_req = 1'b0; we = '0; wa = '0; wd = '0;
    alloc_en = 1'b0; alloc_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy_fall(output int n);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic check_all_zero(input string nm);
    idle_inputs();
    for (int a = 0; a < 32; a++) begin
      ra = {5'(a), 5'(a)};
      #1;
      chk({nm, "_rd0"}, {32'h0, rd[31:0]}, 64'h0);
      chk({nm, "_pend"}, {62'h0, rd_pend}, 64'h0);
    end
  endtask

  initial begin
    int n;
    idle_inputs();
    ra  = '0;
    rst = 1'b1;
    #1 rst = 1'b0;

    vt[0]  = mk(2'b11, 5, 32'h11, 5, 32'h22, 0, 0, 5, 0, 32'h22, 32'h0, 2'b00);
    vt[1]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 5, 5, 32'h22, 32'h22, 2'b00);
    vt[2]  = mk(2'b01, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 5, 32'h0, 32'h22, 2'b00);
    vt[3]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00);
    vt[4]  = mk(2'b00, 0, 0, 0, 0, 1, 7, 5, 7, 32'h22, 32'h0, 2'b00);
    vt[5]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 7, 7, 32'h0, 32'h0, 2'b11);
    vt[6]  = mk(2'b01, 7, 32'h5, 0, 0, 0, 0, 7, 7, 32'h5, 32'h5, 2'b00);
    vt[7]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 7, 7, 32'h5, 32'h5, 2'b00);
    vt[8]  = mk(2'b10, 0, 0, 7, 32'h9, 1, 7, 7, 3, 32'h9, 32'h0, 2'b00);
    vt[9]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 7, 7, 32'h9, 32'h9, 2'b11);
    vt[10] = mk(2'b11, 3, 32'hA, 4, 32'hB, 0, 0, 3, 4, 32'hA, 32'hB, 2'b00);
    vt[11] = mk(2'b00, 0, 0, 0, 0, 0, 0, 3, 4, 32'hA, 32'hB, 2'b00);
    vt[12] = mk(2'b00, 0, 0, 0, 0, 1, 0, 0, 7, 32'h0, 32'h9, 2'b10);
    vt[13] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 32'h0, 32'h9, 2'b10);
    vt[14] = mk(2'b11, 7, 32'h77, 7, 32'h88, 0, 0, 7, 3, 32'h88, 32'hA, 2'b00);
    vt[15] = mk(2'b00, 0, 0, 0, 0, 0, 0, 7, 7, 32'h88, 32'h88, 2'b00);
    vt[16] = mk(2'b01, 4, 32'hCC, 0, 0, 0, 0, 4, 4, 32'hCC, 32'hCC, 2'b00);
    vt[17] = mk(2'b00, 0, 0, 0, 0, 0, 0, 4, 3, 32'hCC, 32'hA, 2'b00);

    // Reset: busy asserted asynchronously, reads forced to zero.
    #1;
    ra = {5'd0, 5'd5};
    #1;
    chk("rst_busy_async", {63'h0, busy}, 64'h1);
    tick();
    tick();
    chk("rst_busy", {63'h0, busy}, 64'h1);
    chk("rst_rd0", {32'h0, rd[31:0]}, 64'h0);
    rst = 1'b1;
    wait_busy_fall(n);
    chk("init_busy_cycles", 64'(n), 64'd32);
    check_all_zero("init");

    // One vector per cycle: drive, check combinational result, advance.
    for (int k = 0; k < 18; k++) begin
      we = vt[k].we;
      wa = {vt[k].wa1, vt[k].wa0};
      wd = {vt[k].wd1, vt[k].wd0};
      alloc_en = vt[k].al_en;
      alloc_addr = vt[k].al_a;
      ra = {vt[k].ra1, vt[k].ra0};
      #2;
      chk($sformatf("vec%0d_rd0", k), {32'h0, rd[31:0]}, {32'h0, vt[k].e0});
      chk($sformatf("vec%0d_rd1", k), {32'h0, rd[63:32]}, {32'h0, vt[k].e1});
      chk($sformatf("vec%0d_pend", k), {62'h0, rd_pend}, {62'h0, vt[k].ep});
      chk($sformatf("vec%0d_busy", k), {63'h0, busy}, 64'h0);
      tick();
    end
    idle_inputs();

    // Bulk clear: writes/allocs and repeated clr_req during busy are dropped.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      idle_inputs();
      if (n == 0) begin
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'hB};
        alloc_en = 1'b1; alloc_addr = 5'd3;
        ra = {5'd7, 5'd3};
        #2;
        chk("clr_busy", {63'h0, busy}, 64'h1);
        chk("clr_rd0_zero", {32'h0, rd[31:0]}, 64'h0);
        chk("clr_pend_zero", {62'h0, rd_pend}, 64'h0);
      end
      if (n >= 5 && n < 10) clr_req = 1'b1;
      tick();
      n++;
    end
    idle_inputs();
    chk("clr_busy_cycles", 64'(n), 64'd32);
    check_all_zero("clr");

    // Async reset from idle, then reset again ten cycles into the clear.
    we = 2'b01; wa = {5'd0, 5'd25}; wd = {32'h0, 32'h99};
    alloc_en = 1'b1; alloc_addr = 5'd20;
    tick();
    idle_inputs();
    ra = {5'd20, 5'd25};
    #2;
    chk("pre_rst_rd0", {32'h0, rd[31:0]}, 64'h99);
    chk("pre_rst_pend", {62'h0, rd_pend}, 64'h2);
    rst = 1'b0;
    #1;
    chk("idle_rst_busy_async", {63'h0, busy}, 64'h1);
    chk("idle_rst_rd0", {32'h0, rd[31:0]}, 64'h0);
    tick();
    rst = 1'b1;
    repeat (10) tick();
    chk("mid_clr_busy", {63'h0, busy}, 64'h1);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    wait_busy_fall(n);
    chk("mid_rst_busy_cycles", 64'(n), 64'd32);
    check_all_zero("mid_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
